// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - shared byte type and width for the rv ready/valid byte link
package rv_pkg;
    localparam int RV_DATA_W = 8;
    typedef logic [RV_DATA_W-1:0] rv_data_t;
endpackage

// File: rtl/rv_if.sv
// rtl/rv_if.sv - ready/valid byte link shared by the transmit and receive ends
interface rv_if;
    import rv_pkg::*;
    logic     valid;
    rv_data_t data;
    logic     ready;

    modport egress  (output valid, output data, input ready);
    modport ingress (input valid, input data, output ready);
endinterface

// File: rtl/rv_tx_mem.sv
// rtl/rv_tx_mem.sv - DEPTH-1 entry byte store behind the rv_tx output register
module rv_tx_mem
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     push,
    input  rv_data_t push_data,
    input  logic     pop,
    output rv_data_t head,
    output logic     full,
    output logic     empty
);
    localparam int ENTRIES = DEPTH - 1;
    localparam int AW = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;
    localparam logic [AW-1:0] LAST = AW'(ENTRIES - 1);

    rv_data_t        mem [ENTRIES];
    logic [AW:0]     wr_ptr;
    logic [AW:0]     rd_ptr;

    // Entry count need not be a power of two, so the index wraps explicitly and flips the wrap bit.
    function automatic logic [AW:0] ptr_inc(input logic [AW:0] p);
        if (p[AW-1:0] == LAST)
            return {~p[AW], {AW{1'b0}}};
        else
            return {p[AW], p[AW-1:0] + 1'b1};
    endfunction

    assign head  = mem[rd_ptr[AW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
        end
    end
endmodule

// File: rtl/rv_tx.sv
// rtl/rv_tx.sv - rv_if transmit end: write port, byte buffer, registered valid/data (RV_TX_STATS_EN adds counters)
module rv_tx
    import rv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  rv_data_t                   wr_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     level,
    output logic                       overflow,
`ifdef RV_TX_STATS_EN
    output logic [31:0]                beat_cnt,
    output logic [31:0]                stall_cnt,
`endif
    rv_if.egress                       rv_e
);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    logic          out_vld;
    rv_data_t      out_dat;
    rv_data_t      mem_head;
    logic          mem_full;
    logic          mem_empty;
    logic          accept;
    logic          transfer;
    logic          load;
    logic          mem_pop;
    logic          bypass;
    logic          mem_push;
    logic [LW-1:0] level_next;

    assign rv_e.valid = out_vld;
    assign rv_e.data  = out_dat;

    // full is the registered flag, so a push seen while full is dropped even if a beat leaves this cycle.
    always_comb begin
        accept     = wr_en && !full;
        transfer   = out_vld && rv_e.ready;
        load       = !out_vld || transfer;
        mem_pop    = load && !mem_empty;
        bypass     = load && mem_empty && accept;
        mem_push   = accept && !bypass && !mem_full;
        level_next = level;
        if (accept && !transfer)
            level_next = level + 1'b1;
        else if (!accept && transfer)
            level_next = level - 1'b1;
    end

    rv_tx_mem #(.DEPTH(DEPTH)) u_mem (
        .clk       (clk),
        .rst       (rst),
        .push      (mem_push),
        .push_data (wr_data),
        .pop       (mem_pop),
        .head      (mem_head),
        .full      (mem_full),
        .empty     (mem_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            out_vld  <= 1'b0;
            out_dat  <= '0;
            level    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            overflow <= 1'b0;
        end else begin
            if (load) begin
                if (!mem_empty) begin
                    out_vld <= 1'b1;
                    out_dat <= mem_head;
                end else if (accept) begin
                    out_vld <= 1'b1;
                    out_dat <= wr_data;
                end else begin
                    out_vld <= 1'b0;
                end
            end
            level    <= level_next;
            full     <= (level_next == LVL_FULL);
            empty    <= (level_next == '0);
            overflow <= wr_en && full;
        end
    end

`ifdef RV_TX_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt  <= '0;
            stall_cnt <= '0;
        end else begin
            if (transfer)
                beat_cnt <= beat_cnt + 32'd1;
            if (out_vld && !rv_e.ready)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif
endmodule
